muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the multicycle core. It accepts one long-latency operation from the main FSM: UMULL, SMULL or UDIV. It runs a 32-step shift-add or restoring-divide loop, then sequences the register-file writeback. The writeback is two ports-worth (RdLo, then RdHi) for long multiplies and one for divides. It sits beside the ALU: decode's `is_mul`/ALUControl select the op, and the main FSM stalls on `busy` until `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand width. The loop counter is log2(WIDTH) bits. The full product is 2*WIDTH.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  one-cycle request; sampled only in IDLE
- `op`  in  2  00 UMULL, 01 SMULL, 10 UDIV, 11 reserved (treated as UDIV)
- `srca`  in  WIDTH  multiplicand / dividend
- `srcb`  in  WIDTH  multiplier / divisor
- `abort`  in  1  flush; cancels an in-flight op with no writeback
- `busy`  out  1  high in every state except IDLE
- `wr_lo`  out  1  register-file write strobe for RdLo / quotient
- `wr_hi`  out  1  register-file write strobe for RdHi
- `result`  out  WIDTH  write data: low word in WBLO, high word (or remainder) in WBHI
- `done`  out  1  one-cycle completion pulse
- `flag_n`, `flag_z`  out  1 each  N/Z of the full result; valid while `done`=1
- `div_zero`  out  1  high with `done` when UDIV had `srcb`=0

## Operation
- States: IDLE, MUL, DIV, WBLO, WBHI.
- IDLE:
  - `start`=1 with op 00/01 → MUL.
  - `start`=1 with op 1x and `srcb`≠0 → DIV.
  - op 1x with `srcb`=0 → WBLO directly.
  - The start edge latches operands and clears the counter.
- MUL: one shift-add step per cycle over unsigned operand magnitudes; 32 steps, counter 0..31.
  - At count 31 → WBLO.
  - SMULL uses |srca|, |srcb| and negates the 64-bit product when the sign bits differ.
  - |0x80000000| is 0x80000000 as an unsigned magnitude.
- DIV: restoring division, one quotient bit per cycle, 32 steps, then → WBLO.
- WBLO:
  - `wr_lo`=1, `result`=low product word / quotient.
  - Mul → WBHI.
  - Div → IDLE, with `done`=1 in WBLO.
- WBHI: `wr_hi`=1, `result`=high product word, `done`=1, → IDLE.
- Divide by zero: quotient 0xFFFFFFFF, remainder = `srca`, `div_zero`=1. Only the quotient is written.
- Flags:
  - Mul: `flag_n`=bit 63, `flag_z`=(64-bit result==0).
  - Div: `flag_n`=quotient bit 31, `flag_z`=(quotient==0).
  - The team's decode gates flag write with the S bit; this block always drives the flags.
- `start` while `busy`=1 is ignored; no queuing.
- `abort`=1 in any non-IDLE state → IDLE on the next edge.
  - No `wr_lo`/`wr_hi`/`done` is asserted in that cycle or later.
  - `abort` has priority over all transitions.
  - `abort` in IDLE has no effect, and `start` is not accepted that cycle.
- Strobes, `done`, `div_zero` and the flags are decoded from registered state, not from inputs.

## Timing
- Reset (`reset`=0), asynchronous:
  - State IDLE, counter 0.
  - Operand/accumulator registers 0.
  - `busy`, `wr_lo`, `wr_hi`, `done`, `flag_n`, `flag_z`, `div_zero` = 0; `result`=0.
- Reset mid-operation discards the operation with no writes.
- Cycle numbering: `start` is high in cycle 0.
  - Cycles 1–32: MUL/DIV, `busy`=1.
  - Cycle 33: WBLO.
  - Cycle 34: WBHI (mul only).
- Latency `start` → `done`: 34 cycles for mul, 33 for div, 1 for divide-by-zero (WBLO in cycle 1).
- IDLE is re-entered the cycle after `done`. Back-to-back `start` is accepted in that IDLE cycle, giving a minimum 35-cycle mul issue interval.
- `wr_lo` and `wr_hi` are never high in the same cycle.
- `done` is high for exactly one cycle per accepted, non-aborted op.

## Test plan
- UMULL 0xFFFFFFFF × 0xFFFFFFFF → `wr_lo` cycle 33 with result 0x00000001. Then `wr_hi` + `done` in cycle 34 with 0xFFFFFFFE, N=1, Z=0.
- SMULL 0xFFFFFFFF (−1) × 0x00000002 → lo 0xFFFFFFFE, hi 0xFFFFFFFF, N=1. Also 0x80000000 × 0x80000000 → hi 0x40000000, lo 0, N=0.
- UDIV 100 / 7 → `wr_lo` + `done` in cycle 33, quotient 14, `div_zero`=0, `wr_hi` never asserted. Then 0 / 5 → quotient 0, Z=1.
- UDIV 5 / 0 → `done` in cycle 1, quotient 0xFFFFFFFF, `div_zero`=1.
- `start` pulsed in cycle 10 of a MUL → ignored, and the original result is unchanged. `abort` in cycle 20 → IDLE in cycle 21 with no strobes. A new `start` in cycle 21 completes normally.
- `reset`=0 in cycle 15 of a DIV → all outputs 0 immediately, with no write. After release, a UMULL 3 × 4 gives lo 12, hi 0, Z=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative UMULL/SMULL/UDIV sequencer: 32-step shift-add or restoring-divide
// loop followed by register-file writeback sequencing (RdLo, then RdHi).
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             wr_lo,
  output logic             wr_hi,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             flag_n,
  output logic             flag_z,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_WBLO = 3'd3;
  localparam logic [2:0] S_WBHI = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_is_div, w_is_div_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_wr_lo, w_wr_lo_nxt;
  logic             r_wr_hi, w_wr_hi_nxt;
  logic             r_done, w_done_nxt;
  logic             r_flag_n, w_flag_n_nxt;
  logic             r_flag_z, w_flag_z_nxt;
  logic             r_div_zero, w_div_zero_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;

  // Operand magnitudes; only SMULL (op[0]=1 with op[1]=0) takes absolute values
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_abs_a = (op[0] && srca[WIDTH-1]) ? (-srca) : srca;
  assign w_abs_b = (op[0] && srcb[WIDTH-1]) ? (-srcb) : srcb;

  // Shift-add step: acc = {partial product hi, multiplier bits remaining}
  logic [WIDTH:0]   w_add;
  logic [AW-1:0]    w_mul_step, w_mul_final;
  assign w_add       = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : (WIDTH+1)'(0));
  assign w_mul_step  = {w_add, r_acc[WIDTH-1:1]};
  assign w_mul_final = r_neg ? (-w_mul_step) : w_mul_step;

  // Restoring-divide step: acc = {remainder, dividend shifting into quotient}
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [AW-1:0]    w_div_step;
  assign w_rem_sh   = {r_acc[AW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_div_step = (!w_diff[WIDTH]) ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                       : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opb      <= '0;
      r_neg      <= 1'b0;
      r_is_div   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_lo    <= 1'b0;
      r_wr_hi    <= 1'b0;
      r_done     <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
      r_opb      <= w_opb_nxt;
      r_neg      <= w_neg_nxt;
      r_is_div   <= w_is_div_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_lo    <= w_wr_lo_nxt;
      r_wr_hi    <= w_wr_hi_nxt;
      r_done     <= w_done_nxt;
      r_flag_n   <= w_flag_n_nxt;
      r_flag_z   <= w_flag_z_nxt;
      r_div_zero <= w_div_zero_nxt;
      r_result   <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_acc_nxt      = r_acc;
    w_opb_nxt      = r_opb;
    w_neg_nxt      = r_neg;
    w_is_div_nxt   = r_is_div;
    w_wr_lo_nxt    = 1'b0;
    w_wr_hi_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_div_zero_nxt = 1'b0;
    w_flag_n_nxt   = r_flag_n;
    w_flag_z_nxt   = r_flag_z;
    w_result_nxt   = '0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_cnt_nxt = '0;
          if (!op[1]) begin
            w_state_nxt  = S_MUL;
            w_is_div_nxt = 1'b0;
            w_acc_nxt    = {{WIDTH{1'b0}}, w_abs_b};
            w_opb_nxt    = w_abs_a;
            w_neg_nxt    = op[0] & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          end else if (srcb != '0) begin
            w_state_nxt  = S_DIV;
            w_is_div_nxt = 1'b1;
            w_acc_nxt    = {{WIDTH{1'b0}}, srca};
            w_opb_nxt    = srcb;
            w_neg_nxt    = 1'b0;
          end else begin
            // Divide by zero: quotient all-ones, remainder = dividend
            w_state_nxt    = S_WBLO;
            w_is_div_nxt   = 1'b1;
            w_acc_nxt      = {srca, {WIDTH{1'b1}}};
            w_opb_nxt      = srcb;
            w_neg_nxt      = 1'b0;
            w_wr_lo_nxt    = 1'b1;
            w_done_nxt     = 1'b1;
            w_div_zero_nxt = 1'b1;
            w_result_nxt   = {WIDTH{1'b1}};
            w_flag_n_nxt   = 1'b1;
            w_flag_z_nxt   = 1'b0;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt = w_mul_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_acc_nxt    = w_mul_final;
          w_state_nxt  = S_WBLO;
          w_wr_lo_nxt  = 1'b1;
          w_result_nxt = w_mul_final[WIDTH-1:0];
          w_flag_n_nxt = w_mul_final[AW-1];
          w_flag_z_nxt = (w_mul_final == '0);
        end
      end
      S_DIV: begin
        w_acc_nxt = w_div_step;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt  = S_WBLO;
          w_wr_lo_nxt  = 1'b1;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_div_step[WIDTH-1:0];
          w_flag_n_nxt = w_div_step[WIDTH-1];
          w_flag_z_nxt = (w_div_step[WIDTH-1:0] == '0);
        end
      end
      S_WBLO: begin
        if (r_is_div) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt  = S_WBHI;
          w_wr_hi_nxt  = 1'b1;
          w_done_nxt   = 1'b1;
          w_result_nxt = r_acc[AW-1:WIDTH];
        end
      end
      S_WBHI:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush wins over every transition and suppresses any pending writeback
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_wr_lo_nxt    = 1'b0;
      w_wr_hi_nxt    = 1'b0;
      w_done_nxt     = 1'b0;
      w_div_zero_nxt = 1'b0;
      w_result_nxt   = '0;
      w_flag_n_nxt   = r_flag_n;
      w_flag_z_nxt   = r_flag_z;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign busy     = r_busy;
  assign wr_lo    = r_wr_lo;
  assign wr_hi    = r_wr_hi;
  assign result   = r_result;
  assign done     = r_done;
  assign flag_n   = r_flag_n;
  assign flag_z   = r_flag_z;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with hand-computed expected results.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb;
  logic         busy, wr_lo, wr_hi, done, flag_n, flag_z, div_zero;
  logic [W-1:0] result;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .abort(abort), .busy(busy), .wr_lo(wr_lo), .wr_hi(wr_hi), .result(result),
    .done(done), .flag_n(flag_n), .flag_z(flag_z), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int lo_cyc, hi_cyc, done_cyc, n_lo, n_hi, n_done, busy_cnt, overlap;
  logic busy_after;
  logic [W-1:0] lo_val, hi_val;
  logic fn, fz, fdz;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issues an op in the current cycle (called at a negedge) and observes until
  // one cycle after done, one cycle after abort, or a mid-op reset.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int xs, input int ab, input int rs);
    lo_cyc = -1; hi_cyc = -1; done_cyc = -1;
    n_lo = 0; n_hi = 0; n_done = 0; busy_cnt = 0; overlap = 0;
    busy_after = 1'bx; lo_val = 'x; hi_val = 'x; fn = 1'bx; fz = 1'bx; fdz = 1'bx;
    op = o; srca = a; srcb = b; start = 1'b1; abort = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done_cyc > 0 && c == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (wr_lo) begin n_lo++; lo_cyc = c; lo_val = result; end
      if (wr_hi) begin n_hi++; hi_cyc = c; hi_val = result; end
      if (wr_lo && wr_hi) overlap++;
      if (busy) busy_cnt++;
      if (done) begin n_done++; done_cyc = c; fn = flag_n; fz = flag_z; fdz = div_zero; end
      if (ab > 0 && c == ab + 1) begin
        busy_after = busy;
        break;
      end
      start = (c == xs);
      if (c == xs) begin op = 2'b10; srca = 32'd5; srcb = 32'd0; end
      abort = (c == ab);
      if (c == rs) begin
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {24'd0, busy, wr_lo, wr_hi, done, flag_n, flag_z, div_zero, result}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic exp_res(input string t, input int elo_cyc, input logic [W-1:0] elo,
                         input int ehi_cyc, input logic [W-1:0] ehi, input int edone,
                         input logic en, input logic ez, input logic edz, input int ebusy);
    chk({t, "_lo_cyc"}, 64'(lo_cyc), 64'(elo_cyc));
    chk({t, "_lo"}, 64'(lo_val), 64'(elo));
    chk({t, "_hi_cyc"}, 64'(hi_cyc), 64'(ehi_cyc));
    if (ehi_cyc > 0) chk({t, "_hi"}, 64'(hi_val), 64'(ehi));
    chk({t, "_done_cyc"}, 64'(done_cyc), 64'(edone));
    chk({t, "_ndone"}, 64'(n_done), 64'd1);
    chk({t, "_nz_dz"}, {61'd0, fn, fz, fdz}, {61'd0, en, ez, edz});
    chk({t, "_busy_cnt"}, 64'(busy_cnt), 64'(ebusy));
    chk({t, "_overlap"}, 64'(overlap), 64'd0);
    chk({t, "_idle_after"}, 64'(busy_after), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {24'd0, busy, wr_lo, wr_hi, done, flag_n, flag_z, div_zero, result}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // abort in IDLE blocks start that cycle
    start = 1'b1; abort = 1'b1; op = 2'b00; srca = 32'd3; srcb = 32'd3;
    @(negedge clk);
    chk("idle_abort_busy", 64'(busy), 64'd0);
    start = 1'b0; abort = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    exp_res("umull_ff", 33, 32'h0000_0001, 34, 32'hFFFF_FFFE, 34, 1'b1, 1'b0, 1'b0, 34);

    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
    exp_res("smull_m1x2", 33, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFF, 34, 1'b1, 1'b0, 1'b0, 34);

    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    exp_res("smull_min", 33, 32'h0000_0000, 34, 32'h4000_0000, 34, 1'b0, 1'b0, 1'b0, 34);

    run_op(2'b10, 32'd100, 32'd7, 0, 0, 0);
    exp_res("udiv_100_7", 33, 32'd14, -1, 32'd0, 33, 1'b0, 1'b0, 1'b0, 33);

    run_op(2'b10, 32'd0, 32'd5, 0, 0, 0);
    exp_res("udiv_0_5", 33, 32'd0, -1, 32'd0, 33, 1'b0, 1'b1, 1'b0, 33);

    run_op(2'b11, 32'd5, 32'd0, 0, 0, 0);
    exp_res("udiv_dz", 1, 32'hFFFF_FFFF, -1, 32'd0, 1, 1'b1, 1'b0, 1'b1, 1);

    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 10, 0, 0);
    exp_res("mul_ign_start", 33, 32'h0000_0000, 34, 32'h0000_0001, 34, 1'b0, 1'b0, 1'b0, 34);

    run_op(2'b00, 32'd9, 32'd9, 0, 20, 0);
    chk("abort_idle21", 64'(busy_after), 64'd0);
    chk("abort_no_wr", 64'(n_lo + n_hi + n_done), 64'd0);

    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    exp_res("smull_after_abort", 33, 32'hFFFF_FFF1, 34, 32'hFFFF_FFFF, 34, 1'b1, 1'b0, 1'b0, 34);

    run_op(2'b10, 32'd100, 32'd7, 0, 0, 15);
    chk("rst_no_wr", 64'(n_lo + n_hi + n_done), 64'd0);

    run_op(2'b00, 32'd3, 32'd4, 0, 0, 0);
    exp_res("umull_3x4", 33, 32'd12, 34, 32'd0, 34, 1'b0, 1'b0, 1'b0, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
